// File: rtl/i2s_rx_frame.sv
// I2S / left-justified stereo receiver: oversampled serial capture, framing FSM, 2-entry FWFT FIFO.
// Define I2S_RX_STATS_EN to add cnt_clr, err_cnt and drop_cnt.
module i2s_rx_frame #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned MAX_SLOT    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lj_mode,
  input  logic              I2S_sclk,
  input  logic              I2S_ws,
  input  logic              I2S_data,
  output logic [DATA_W-1:0] lft_chnnl,
  output logic [DATA_W-1:0] rght_chnnl,
  output logic              vld,
  input  logic              rdy,
  output logic              locked,
  output logic              frm_err,
  output logic              ovfl
`ifdef I2S_RX_STATS_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       err_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {StHunt = 2'd0, StLeft = 2'd1, StRight = 2'd2} state_e;

  localparam int unsigned      CntW     = 6;
  localparam logic [CntW-1:0] CntDataW = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntMax   = CntW'(MAX_SLOT);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ws_sync_q, data_sync_q;
  logic                   sclk_prev_q, ws_prev_q, eff_prev_q;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [DATA_W-1:0]      sr_q, left_q;
  logic                   frm_err_q, ovfl_q;

  logic sclk_s, ws_s, data_s, sclk_rise;
  logic eff_ws, boundary, into_left, slot_full, push_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], I2S_sclk};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], I2S_ws};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], I2S_data};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // In I2S mode WS leads the data by one SCLK, so the channel owning this bit is last rise's WS.
  assign eff_ws    = lj_mode ? ws_s : ws_prev_q;
  assign boundary  = eff_ws != eff_prev_q;
  assign into_left = boundary && (eff_ws == lj_mode);
  assign slot_full = cnt_q >= CntDataW;
  assign push_req  = sclk_rise && (state_q == StRight) && boundary && slot_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
      eff_prev_q  <= 1'b0;
      state_q     <= StHunt;
      cnt_q       <= '0;
      sr_q        <= '0;
      left_q      <= '0;
      frm_err_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      frm_err_q   <= 1'b0;
      if (sclk_rise) begin
        ws_prev_q  <= ws_s;
        eff_prev_q <= eff_ws;
        if (boundary) begin
          cnt_q <= CntW'(1);
          sr_q  <= {{(DATA_W-1){1'b0}}, data_s};
        end else begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (cnt_q < CntDataW) sr_q <= {sr_q[DATA_W-2:0], data_s};
        end
        case (state_q)
          StHunt: begin
            if (into_left) state_q <= StLeft;
          end
          StLeft: begin
            if (boundary) begin
              if (slot_full) begin
                left_q  <= sr_q;
                state_q <= StRight;
              end else begin
                frm_err_q <= 1'b1;
                state_q   <= StHunt;
              end
            end else if (cnt_q == CntMax) begin
              frm_err_q <= 1'b1;
              state_q   <= StHunt;
            end
          end
          StRight: begin
            if (boundary) begin
              if (slot_full) begin
                state_q <= StLeft;
              end else begin
                frm_err_q <= 1'b1;
                state_q   <= StHunt;
              end
            end else if (cnt_q == CntMax) begin
              frm_err_q <= 1'b1;
              state_q   <= StHunt;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  logic [2*DATA_W-1:0] mem_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                full, pop, push_ok;

  assign full    = count_q == 2'd2;
  assign pop     = vld && rdy;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the frame.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovfl_q   <= 1'b0;
    end else begin
      ovfl_q <= push_req && full && !pop;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {left_q, sr_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign {lft_chnnl, rght_chnnl} = mem_q[rd_ptr_q];
  assign vld     = count_q != 2'd0;
  assign locked  = (state_q == StLeft) || (state_q == StRight);
  assign frm_err = frm_err_q;
  assign ovfl    = ovfl_q;

`ifdef I2S_RX_STATS_EN
  logic [15:0] err_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (cnt_clr) begin
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (frm_err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (ovfl_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_frame.sv
// Scoreboard bench for i2s_rx_frame: directed serial streams, expected frames queued, monitor pops.
module tb_i2s_rx_frame;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst, lj_mode, I2S_sclk, I2S_ws, I2S_data, rdy;
  logic [DW-1:0] lft_chnnl, rght_chnnl;
  logic          vld, locked, frm_err, ovfl;
`ifdef I2S_RX_STATS_EN
  logic          cnt_clr;
  logic [15:0]   err_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  i2s_rx_frame #(.DATA_W(DW), .MAX_SLOT(32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .lj_mode    (lj_mode),
    .I2S_sclk   (I2S_sclk),
    .I2S_ws     (I2S_ws),
    .I2S_data   (I2S_data),
    .lft_chnnl  (lft_chnnl),
    .rght_chnnl (rght_chnnl),
    .vld        (vld),
    .rdy        (rdy),
    .locked     (locked),
    .frm_err    (frm_err),
    .ovfl       (ovfl)
`ifdef I2S_RX_STATS_EN
    ,
    .cnt_clr    (cnt_clr),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [47:0] exp_q[$];
  logic        eff_s[$];
  logic        bit_s[$];
  int          err_rise_q[$];
  int          rise_idx = -1;
  int          err_seen = 0;
  int          ovfl_seen = 0;
  int          lock_rise = -1;
  bit          lock_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One channel slot; bits past the 24-bit word are padded with zeros.
  task automatic add_slot(input logic lvl, input logic [23:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      eff_s.push_back(lvl);
      bit_s.push_back((i < 24) ? word[23-i] : 1'b0);
    end
  endtask

  task automatic add_frame(input logic lft_lvl, input logic [23:0] l, input logic [23:0] r);
    add_slot(lft_lvl, l, 32);
    add_slot(!lft_lvl, r, 32);
  endtask

  // i2s_framing: WS leads its slot by one SCLK. pulse_idx: rise at which rdy is pulsed for 1 clk.
  task automatic play(input logic i2s_framing, input int pulse_idx);
    int n;
    n = eff_s.size();
    for (int k = 0; k < n; k++) begin
      I2S_ws   = (i2s_framing && (k + 1 < n)) ? eff_s[k+1] : eff_s[k];
      I2S_data = bit_s[k];
      repeat (4) @(posedge clk);
      #1;
      rise_idx = k;
      I2S_sclk = 1'b1;
      repeat (2) @(posedge clk);
      if (k == pulse_idx) begin
        #1 rdy = 1'b1;
      end
      @(posedge clk);
      if (k == pulse_idx) begin
        #1 rdy = 1'b0;
      end
      @(posedge clk);
      #1 I2S_sclk = 1'b0;
    end
    eff_s.delete();
    bit_s.delete();
  endtask

  task automatic do_reset(input logic lj, input bit chk);
    rst      = 1'b1;
    lj_mode  = lj;
    I2S_sclk = 1'b0;
    I2S_ws   = 1'b0;
    I2S_data = 1'b0;
    rdy      = 1'b0;
`ifdef I2S_RX_STATS_EN
    cnt_clr  = 1'b0;
`endif
    #1;
    exp_q.delete();
    err_rise_q.delete();
    err_seen  = 0;
    ovfl_seen = 0;
    lock_seen = 1'b0;
    lock_rise = -1;
    rise_idx  = -1;
    repeat (2) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_vld", vld, 0);
      check("rst_locked", locked, 0);
      check("rst_frm_err", frm_err, 0);
      check("rst_ovfl", ovfl, 0);
      check("rst_lft", lft_chnnl, 0);
      check("rst_rght", rght_chnnl, 0);
`ifdef I2S_RX_STATS_EN
      check("rst_err_cnt", err_cnt, 0);
      check("rst_drop_cnt", drop_cnt, 0);
`endif
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    rdy = 1'b1;
    while ((vld || exp_q.size() != 0) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_drain_in_time"}, (t < 50), 1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vld && rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h_%h, required no frame", lft_chnnl, rght_chnnl);
        end else begin
          check("sb_frame", {lft_chnnl, rght_chnnl}, exp_q.pop_front());
        end
      end
      if (frm_err) begin
        err_seen++;
        err_rise_q.push_back(rise_idx);
        check("locked_on_err", locked, 0);
      end
      if (ovfl) ovfl_seen++;
      if (locked && !lock_seen) begin
        lock_seen = 1'b1;
        lock_rise = rise_idx;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset(1'b0, 1'b1);

    // I2S, three identical frames
    rdy = 1'b1;
    add_slot(1'b1, 24'h0, 32);
    for (int f = 0; f < 3; f++) begin
      add_frame(1'b0, 24'hABCDEF, 24'h123456);
      exp_q.push_back({24'hABCDEF, 24'h123456});
    end
    add_slot(1'b0, 24'h0, 4);
    play(1'b1, -1);
    drain("i2s");
    check("i2s_lock_rise", lock_rise, 32);
    check("i2s_locked", locked, 1);
    check("i2s_no_err", err_seen, 0);

    // Left-justified, WS high = left
    do_reset(1'b1, 1'b0);
    rdy = 1'b1;
    add_slot(1'b0, 24'h0, 32);
    for (int f = 0; f < 3; f++) begin
      add_frame(1'b1, 24'hABCDEF, 24'h123456);
      exp_q.push_back({24'hABCDEF, 24'h123456});
    end
    add_slot(1'b1, 24'h0, 4);
    play(1'b0, -1);
    drain("lj");
    check("lj_lock_rise", lock_rise, 32);
    check("lj_no_err", err_seen, 0);

    // I2S framing into an LJ-configured receiver: channels swap and shift right by one bit
    do_reset(1'b1, 1'b0);
    rdy = 1'b1;
    add_slot(1'b1, 24'h0, 32);
    add_frame(1'b0, 24'hABCDEF, 24'h123456);
    add_frame(1'b0, 24'hABCDEF, 24'h123456);
    add_slot(1'b0, 24'h0, 4);
    exp_q.push_back({24'h000000, 24'h55E6F7});
    exp_q.push_back({24'h091A2B, 24'h55E6F7});
    play(1'b1, -1);
    drain("mismatch");
    check("mismatch_no_err", err_seen, 0);

    // Short right slot, then WS stuck for 40 SCLKs after lock
    do_reset(1'b0, 1'b0);
    rdy = 1'b1;
    add_slot(1'b1, 24'h0, 32);
    add_frame(1'b0, 24'h111111, 24'h222222);
    add_slot(1'b0, 24'h333333, 32);
    add_slot(1'b1, 24'h444444, 20);
    add_frame(1'b0, 24'h555555, 24'h666666);
    add_frame(1'b0, 24'h777777, 24'h888888);
    add_slot(1'b0, 24'h999999, 40);
    add_slot(1'b1, 24'hAAAAAA, 32);
    add_frame(1'b0, 24'hBBBBBB, 24'hCCCCCC);
    add_slot(1'b0, 24'h0, 4);
    exp_q.push_back({24'h111111, 24'h222222});
    exp_q.push_back({24'h777777, 24'h888888});
    exp_q.push_back({24'hBBBBBB, 24'hCCCCCC});
    play(1'b1, -1);
    drain("err");
    check("err_count", err_seen, 2);
    if (err_rise_q.size() > 0) check("err_short_rise", err_rise_q[0], 148);
    if (err_rise_q.size() > 1) check("err_stuck_rise", err_rise_q[1], 308);
    check("err_relocked", locked, 1);
`ifdef I2S_RX_STATS_EN
    check("stats_err_cnt", err_cnt, 16'h0002);
    check("stats_drop_cnt0", drop_cnt, 16'h0000);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("stats_err_cnt_clr", err_cnt, 16'h0000);
`endif

    // Back-pressure: frames 3,4 dropped, frame 5 pushed while full with a same-cycle pop
    do_reset(1'b0, 1'b0);
    rdy = 1'b0;
    add_slot(1'b1, 24'h0, 32);
    for (int f = 1; f <= 5; f++) begin
      add_frame(1'b0, 24'hA00000 + 24'(f), 24'hB00000 + 24'(f));
    end
    add_slot(1'b0, 24'h0, 4);
    exp_q.push_back({24'hA00001, 24'hB00001});
    exp_q.push_back({24'hA00002, 24'hB00002});
    exp_q.push_back({24'hA00005, 24'hB00005});
    play(1'b1, 352);
    check("full_ovfl_count", ovfl_seen, 2);
    check("full_vld", vld, 1);
`ifdef I2S_RX_STATS_EN
    check("stats_drop_cnt", drop_cnt, 16'h0002);
`endif
    drain("full");

    // Reset mid-left-slot with one frame buffered
    do_reset(1'b0, 1'b0);
    rdy = 1'b0;
    add_slot(1'b1, 24'h0, 32);
    add_frame(1'b0, 24'hC0FFEE, 24'h0BADF0);
    add_slot(1'b0, 24'h123456, 10);
    play(1'b1, -1);
    check("pre_rst_vld", vld, 1);
    check("pre_rst_lft", lft_chnnl, 24'hC0FFEE);
    check("pre_rst_rght", rght_chnnl, 24'h0BADF0);
    check("pre_rst_locked", locked, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", vld, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_lft", lft_chnnl, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_vld", vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
